// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - N-master to 1-slave Wishbone B3 round-robin arbiter with bus timeout
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]          m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]          m_bte_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS-1:0]            m_rty_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic [DATA_WIDTH/8-1:0]           s_sel_o,
  output logic                              s_we_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic [2:0]                        s_cti_o,
  output logic [1:0]                        s_bte_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  input  logic                              s_rty_i,
  output logic [NUM_MASTERS-1:0]            gnt_o,
  output logic                              timeout_o,
  output logic [2:0]                        timeout_master_o
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t                 state, state_nxt;
  logic [2:0]             g, g_nxt, ptr, ptr_nxt, tm, tm_nxt, pick, g_inc;
  logic [NUM_MASTERS-1:0] gnt, gnt_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   found, busy, term, fwd, timeout_hit;

  logic [ADDR_WIDTH-1:0]  sel_adr;
  logic [DATA_WIDTH-1:0]  sel_dat;
  logic [SEL_W-1:0]       sel_sel;
  logic                   sel_we, sel_cyc, sel_stb;
  logic [2:0]             sel_cti;
  logic [1:0]             sel_bte;

  // Signals of the currently granted master
  always_comb begin
    sel_adr = '0;
    sel_dat = '0;
    sel_sel = '0;
    sel_we  = 1'b0;
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_cti = '0;
    sel_bte = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (g == 3'(k)) begin
        sel_adr = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_dat = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_sel = m_sel_i[k*SEL_W +: SEL_W];
        sel_we  = m_we_i[k];
        sel_cyc = m_cyc_i[k];
        sel_stb = m_stb_i[k];
        sel_cti = m_cti_i[k*3 +: 3];
        sel_bte = m_bte_i[k*2 +: 2];
      end
    end
  end

  // First requester at or above the pointer, otherwise wrap to the lowest requester
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && (3'(k) >= ptr) && m_cyc_i[k]) begin
        pick  = 3'(k);
        found = 1'b1;
      end
    end
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && m_cyc_i[k]) begin
        pick  = 3'(k);
        found = 1'b1;
      end
    end
  end

  assign g_inc = (g == LAST_IDX) ? 3'd0 : g + 3'd1;
  assign busy  = (state == BUSY);
  assign term  = s_ack_i | s_err_i | s_rty_i;
  assign fwd   = busy & sel_cyc & rst_n;

  assign s_adr_o = busy ? sel_adr : '0;
  assign s_dat_o = busy ? sel_dat : '0;
  assign s_sel_o = busy ? sel_sel : '0;
  assign s_we_o  = busy & sel_we;
  assign s_cyc_o = busy & sel_cyc;
  assign s_stb_o = busy & sel_cyc & sel_stb;
  assign s_cti_o = busy ? sel_cti : '0;
  assign s_bte_o = busy ? sel_bte : '0;
  assign m_dat_o = s_dat_i;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && s_stb_o && !term && (cnt == CNT_LAST);

  always_comb begin
    for (int k = 0; k < NUM_MASTERS; k++) begin
      m_ack_o[k] = fwd && (g == 3'(k)) && s_ack_i;
      m_rty_o[k] = fwd && (g == 3'(k)) && s_rty_i;
      m_err_o[k] = (g == 3'(k)) && ((fwd && s_err_i) || ((state == ABORT) && rst_n));
    end
  end

  assign gnt_o            = gnt;
  assign timeout_o        = (state == ABORT);
  assign timeout_master_o = tm;

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    tm_nxt    = tm;
    cnt_nxt   = (!s_stb_o || term || timeout_hit) ? '0 : cnt + 1'b1;
    case (state)
      IDLE: begin
        if (|m_cyc_i) begin
          state_nxt = BUSY;
          g_nxt     = pick;
          gnt_nxt   = NUM_MASTERS'(1) << pick;
        end
      end
      BUSY: begin
        if (!sel_cyc) begin
          state_nxt = IDLE;
          ptr_nxt   = g_inc;
          gnt_nxt   = '0;
        end else if (timeout_hit) begin
          state_nxt = ABORT;
          tm_nxt    = g;
        end
      end
      ABORT: begin
        // Late terminations are ignored; the owner keeps the bus only if still cycling
        if (sel_cyc) begin
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
          ptr_nxt   = g_inc;
          gnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= '0;
      gnt   <= '0;
      tm    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      tm    <= tm_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - directed self-checking bench for wb_rr_arbiter (2 masters, timeout 8)
module tb_wb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] m_adr_i, m_dat_i;
  logic [7:0]  m_sel_i;
  logic [1:0]  m_we_i, m_cyc_i, m_stb_i;
  logic [5:0]  m_cti_i;
  logic [3:0]  m_bte_i;
  logic [31:0] m_dat_o;
  logic [1:0]  m_ack_o, m_err_o, m_rty_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  gnt_o;
  logic        timeout_o;
  logic [2:0]  timeout_master_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_g;

  wb_rr_arbiter #(
    .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o), .timeout_master_o(timeout_master_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
    m_cyc_i = '0; m_stb_i = '0; m_cti_i = '0; m_bte_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt_o), 'h0);
    chk("rst_cyc", 32'(s_cyc_o), 'h0);
    chk("rst_stb", 32'(s_stb_o), 'h0);
    chk("rst_timeout", 32'(timeout_o), 'h0);
    chk("rst_tmaster", 32'(timeout_master_o), 'h0);
    chk("rst_ack", 32'(m_ack_o), 'h0);
    chk("rst_err", 32'(m_err_o), 'h0);

    // single write from master 0, slave acks on the third bus cycle
    rst_n = 1'b1;
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b01;
    m_adr_i[31:0] = 32'h1000; m_dat_i[31:0] = 32'hDEADBEEF; m_sel_i[3:0] = 4'hF;
    #1;
    chk("t1_req_cyc", 32'(s_cyc_o), 'h0);
    chk("t1_req_gnt", 32'(gnt_o), 'h0);
    tick();
    chk("t1_gnt", 32'(gnt_o), 'h1);
    chk("t1_cyc", 32'(s_cyc_o), 'h1);
    chk("t1_stb", 32'(s_stb_o), 'h1);
    chk("t1_adr", s_adr_o, 32'h1000);
    chk("t1_dat", s_dat_o, 32'hDEADBEEF);
    chk("t1_we", 32'(s_we_o), 'h1);
    chk("t1_sel", 32'(s_sel_o), 'hF);
    chk("t1_noack0", 32'(m_ack_o), 'h0);
    tick();
    chk("t1_noack1", 32'(m_ack_o), 'h0);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hCAFE0001;
    #1;
    chk("t1_ack", 32'(m_ack_o), 'h1);
    chk("t1_rdat", m_dat_o, 32'hCAFE0001);
    tick();
    s_ack_i = 1'b0; m_cyc_i = 2'b00; m_stb_i = 2'b00; m_we_i = 2'b00;
    #1;
    chk("t1_ack_once", 32'(m_ack_o), 'h0);
    chk("t1_drop_cyc", 32'(s_cyc_o), 'h0);
    tick();
    chk("t1_idle_gnt", 32'(gnt_o), 'h0);

    // simultaneous request right after reset: master 0 first, then one dead cycle, then master 1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    m_adr_i[31:0] = 32'h2000; m_adr_i[63:32] = 32'h3000;
    tick();
    chk("t2_gnt0", 32'(gnt_o), 'h1);
    chk("t2_adr0", s_adr_o, 32'h2000);
    s_ack_i = 1'b1;
    #1;
    chk("t2_ack0", 32'(m_ack_o), 'h1);
    tick();
    s_ack_i = 1'b0; m_cyc_i = 2'b10; m_stb_i = 2'b10;
    #1;
    chk("t2_release_cyc", 32'(s_cyc_o), 'h0);
    tick();
    chk("t2_dead_gnt", 32'(gnt_o), 'h0);
    chk("t2_dead_cyc", 32'(s_cyc_o), 'h0);
    tick();
    chk("t2_gnt1", 32'(gnt_o), 'h2);
    chk("t2_adr1", s_adr_o, 32'h3000);
    s_err_i = 1'b1;
    #1;
    chk("t2_err1", 32'(m_err_o), 'h2);
    chk("t2_err_noack", 32'(m_ack_o), 'h0);
    tick();
    s_err_i = 1'b0; m_cyc_i = 2'b00; m_stb_i = 2'b00;
    tick();

    // both masters keep requesting: grants alternate
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    for (int r = 0; r < 4; r++) begin
      exp_g = (r % 2 == 1) ? 2'b10 : 2'b01;
      tick();
      chk("t3_gnt", 32'(gnt_o), 32'(exp_g));
      s_ack_i = 1'b1;
      #1;
      chk("t3_ack", 32'(m_ack_o), 32'(exp_g));
      tick();
      s_ack_i = 1'b0; m_cyc_i = ~exp_g; m_stb_i = ~exp_g;
      tick();
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
    end
    m_cyc_i = 2'b00; m_stb_i = 2'b00;

    // master 1 stalls: abort after 8 strobe cycles
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_adr_i[63:32] = 32'h4000;
    tick();
    chk("t4_gnt", 32'(gnt_o), 'h2);
    repeat (7) tick();
    chk("t4_pre_timeout", 32'(timeout_o), 'h0);
    chk("t4_pre_stb", 32'(s_stb_o), 'h1);
    tick();
    s_ack_i = 1'b1;
    #1;
    chk("t4_timeout", 32'(timeout_o), 'h1);
    chk("t4_err", 32'(m_err_o), 'h2);
    chk("t4_cyc", 32'(s_cyc_o), 'h0);
    chk("t4_stb", 32'(s_stb_o), 'h0);
    chk("t4_tmaster", 32'(timeout_master_o), 'h1);
    chk("t4_late_ack", 32'(m_ack_o), 'h0);
    tick();
    s_ack_i = 1'b0;
    #1;
    chk("t4_resume_to", 32'(timeout_o), 'h0);
    chk("t4_resume_gnt", 32'(gnt_o), 'h2);
    chk("t4_resume_cyc", 32'(s_cyc_o), 'h1);
    chk("t4_resume_err", 32'(m_err_o), 'h0);
    // ack lands exactly on the threshold cycle: termination wins
    repeat (7) tick();
    s_ack_i = 1'b1;
    #1;
    chk("t4_edge_ack", 32'(m_ack_o), 'h2);
    chk("t4_edge_to", 32'(timeout_o), 'h0);
    tick();
    s_ack_i = 1'b0;
    #1;
    chk("t4_no_abort", 32'(timeout_o), 'h0);
    chk("t4_no_abort_cyc", 32'(s_cyc_o), 'h1);
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    tick();

    // 4-beat incrementing burst from master 0 while master 1 waits
    m_cyc_i = 2'b11; m_stb_i = 2'b11; m_cti_i = 6'b000_010; m_bte_i = 4'b0000;
    m_adr_i[31:0] = 32'h5000;
    tick();
    for (int b = 0; b < 4; b++) begin
      m_adr_i[31:0] = 32'h5000 + 32'(4 * b);
      if (b == 3) m_cti_i[2:0] = 3'b111;
      s_ack_i = 1'b1;
      #1;
      chk("t5_gnt", 32'(gnt_o), 'h1);
      chk("t5_ack", 32'(m_ack_o), 'h1);
      chk("t5_cti", 32'(s_cti_o), (b == 3) ? 32'h7 : 32'h2);
      chk("t5_adr", s_adr_o, 32'h5000 + 32'(4 * b));
      tick();
    end
    s_ack_i = 1'b0; m_cyc_i = 2'b10; m_stb_i = 2'b10; m_cti_i = '0;
    #1;
    chk("t5_hold_gnt", 32'(gnt_o), 'h1);
    chk("t5_release_cyc", 32'(s_cyc_o), 'h0);
    tick();
    chk("t5_dead_gnt", 32'(gnt_o), 'h0);
    tick();
    chk("t5_gnt1", 32'(gnt_o), 'h2);

    // reset pulse during master 1 transfer
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    rst_n = 1'b0; s_ack_i = 1'b1;
    #1;
    chk("t6_no_ack", 32'(m_ack_o), 'h0);
    tick();
    rst_n = 1'b1; s_ack_i = 1'b0;
    #1;
    chk("t6_gnt", 32'(gnt_o), 'h0);
    chk("t6_cyc", 32'(s_cyc_o), 'h0);
    tick();
    chk("t6_restart_gnt", 32'(gnt_o), 'h1);
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
